uch_chain: RTL

- Synchronous N-digit up counter, 4 bits per digit; the count-up companion to the team's single-digit down counter.
- Each digit runs in hex (0..F) or decade (0..9) mode, selected by one mode input.
- Provides synchronous load, cascade carry-out, terminal-count and compare-match flags, and a sticky overflow.
- Sits in timer/display datapaths; cascades with further instances through uch_co.

---
 rtl/uch_pkg.sv | 23 ++
 rtl/uch_digit.sv | 35 +++
 rtl/uch_chain.sv | 92 +++++++++
 3 files changed

// File: rtl/uch_pkg.sv
// Shared constants and helpers for the uch_chain up-counter family.
package uch_pkg;

   localparam int DIG_W = 4;

   localparam logic [DIG_W-1:0] HEX_MAX = 4'hF;
   localparam logic [DIG_W-1:0] DEC_MAX = 4'h9;

   typedef enum logic {
      MODE_HEX = 1'b0,
      MODE_DEC = 1'b1
   } uch_mode_e;

   // A digit is terminal when the next increment must wrap it to zero.
   // In decade mode anything at or above 9 counts, so out-of-range loads recover.
   function automatic logic digitTerm(input logic [DIG_W-1:0] value, input logic sel);
      if (sel == MODE_DEC) begin
         return (value >= DEC_MAX);
      end
      return (value == HEX_MAX);
   endfunction

endpackage

// File: rtl/uch_digit.sv
// One 4-bit counter digit with synchronous reset, load and increment.
module uch_digit
   import uch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [DIG_W-1:0] ld_val,
   input  logic             inc,
   input  logic             sel,
   output logic [DIG_W-1:0] q,
   output logic             term
);

   logic [DIG_W-1:0] r_q;

   assign q    = r_q;
   assign term = digitTerm(r_q, sel);

   // Digit register: reset beats load beats increment; a terminal digit wraps to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= ld_val;
      end else if (inc) begin
         if (term) begin
            r_q <= '0;
         end else begin
            r_q <= r_q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/uch_chain.sv
// N-digit synchronous up counter (hex or decade digits) with load, carry,
// terminal-count, compare-match and sticky overflow.
module uch_chain
   import uch_pkg::*;
#(
   parameter int DIGITS = 2
)
(
   input  logic                    uch_clk,
   input  logic                    uch_rst,
   input  logic                    uch_en,
   input  logic                    uch_sel,
   input  logic                    uch_ld,
   input  logic [DIG_W*DIGITS-1:0] uch_d,
   input  logic [DIG_W*DIGITS-1:0] uch_cmp,
   output logic [DIG_W*DIGITS-1:0] uch_q,
   output logic                    uch_tc,
   output logic                    uch_co,
   output logic                    uch_match,
   output logic                    uch_ovf
);

   localparam int W = DIG_W * DIGITS;

   logic [DIGITS-1:0] w_term;
   logic [DIGITS-1:0] w_inc;
   logic [W-1:0]      w_q;
   logic [W-1:0]      w_next;
   logic              w_countEdge;
   logic              r_match;
   logic              r_ovf;

   assign w_countEdge = uch_en & ~uch_ld;

   // Look-ahead carry: each digit steps when every lower digit is terminal,
   // all on the same clock edge. w_next mirrors what the digits will hold
   // after an enabled edge so the match compare can be registered with it.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_first
         assign w_inc[i] = w_countEdge;
      end else begin : g_rest
         assign w_inc[i] = w_countEdge & (&w_term[i-1:0]);
      end

      assign w_next[i*DIG_W +: DIG_W] =
         w_inc[i] ? (w_term[i] ? '0 : w_q[i*DIG_W +: DIG_W] + 4'd1)
                  : w_q[i*DIG_W +: DIG_W];

      uch_digit u_digit (
         .clk    (uch_clk),
         .rst    (uch_rst),
         .ld     (uch_ld),
         .ld_val (uch_d[i*DIG_W +: DIG_W]),
         .inc    (w_inc[i]),
         .sel    (uch_sel),
         .q      (w_q[i*DIG_W +: DIG_W]),
         .term   (w_term[i])
      );
   end

   assign uch_q     = w_q;
   assign uch_tc    = &w_term;
   assign uch_co    = uch_tc & w_countEdge & ~uch_rst;
   assign uch_match = r_match;
   assign uch_ovf   = r_ovf;

   // Match pulses only on the edge that creates the matching value, so holding
   // or changing the compare value alone leaves it low.
   always_ff @(posedge uch_clk) begin
      if (uch_rst) begin
         r_match <= 1'b0;
      end else if (uch_ld) begin
         r_match <= (uch_d == uch_cmp);
      end else if (uch_en) begin
         r_match <= (w_next == uch_cmp);
      end else begin
         r_match <= 1'b0;
      end
   end

   // Overflow sets on a full wrap and sticks until reset or load.
   always_ff @(posedge uch_clk) begin
      if (uch_rst) begin
         r_ovf <= 1'b0;
      end else if (uch_ld) begin
         r_ovf <= 1'b0;
      end else if (uch_en && uch_tc) begin
         r_ovf <= 1'b1;
      end
   end

endmodule
